nlink_tx: RTL and testbench

Link transmitter that drains a first-word-fall-through `nfifo_inf` input buffer and drives flits onto a router-to-router link under credit-based flow control. It sits directly downstream of the FIFO: it consumes `empty_o`/`data_o` and generates the FIFO's `read_i`. It also checks packet framing (head/body/tail) and counts completed packets.

---
 rtl/noc_link_pkg.sv | 24 ++
 rtl/nlink_tx_if.sv | 21 ++
 rtl/nlink_credit_ctr.sv | 29 ++
 rtl/nlink_tx.sv | 82 ++++++++
 tb/tb_nlink_tx.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_link_pkg.sv
// rtl/noc_link_pkg.sv - flit type/state encodings and type-field helpers for the link transmitter
package noc_link_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } tx_state_e;

  function automatic int TYPE_MSB(input int width);
    return width - 1;
  endfunction

  function automatic int TYPE_LSB(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/nlink_tx_if.sv
// rtl/nlink_tx_if.sv - FIFO-side and link-side flit signals of the link transmitter
interface nlink_tx_if #(
  parameter int width = 8
);
  logic             empty_i;
  logic [width-1:0] data_i;
  logic             read_o;
  logic             valid_o;
  logic [width-1:0] data_o;
  logic             credit_i;

  modport master (
    input  empty_i, data_i, credit_i,
    output read_o, valid_o, data_o
  );

  modport slave (
    output empty_i, data_i, credit_i,
    input  read_o, valid_o, data_o
  );
endinterface

// File: rtl/nlink_credit_ctr.sv
// rtl/nlink_credit_ctr.sv - saturating downstream credit counter with overflow detect
module nlink_credit_ctr #(
  parameter int credits = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dec,
  input  logic                           inc,
  output logic [$clog2(credits+1)-1:0]   cnt,
  output logic                           nonzero,
  output logic                           overflow
);
  localparam int CW = $clog2(credits + 1);
  localparam logic [CW-1:0] MAX = CW'(credits);

  assign nonzero  = (cnt != '0);
  // A returned credit with a full count and no pop has nowhere to go.
  assign overflow = inc & ~dec & (cnt == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= MAX;
    end else if (dec & ~inc) begin
      cnt <= cnt - 1'b1;
    end else if (inc & ~dec & ~overflow) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/nlink_tx.sv
// rtl/nlink_tx.sv - credit-flow-controlled link transmitter with framing check and packet count
module nlink_tx
  import noc_link_pkg::*;
#(
  parameter int width   = 8,
  parameter int credits = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  nlink_tx_if.master                   bus,
  output logic [$clog2(credits+1)-1:0] credit_cnt_o,
  output logic                         err_o,
  output logic [15:0]                  pkt_cnt_o
);
  localparam int TMSB = TYPE_MSB(width);
  localparam int TLSB = TYPE_LSB(width);

  logic             pop;
  logic             nonzero;
  logic             overflow;
  logic             valid_q;
  logic [width-1:0] data_q;
  flit_type_e       ftype;
  tx_state_e        state;

  assign pop         = ~rst_i & ~bus.empty_i & nonzero;
  assign bus.read_o  = pop;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign ftype       = flit_type_e'(bus.data_i[TMSB:TLSB]);

  nlink_credit_ctr #(.credits(credits)) u_credit (
    .clk      (clk_i),
    .rst      (rst_i),
    .dec      (pop),
    .inc      (bus.credit_i),
    .cnt      (credit_cnt_o),
    .nonzero  (nonzero),
    .overflow (overflow)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      state     <= IDLE;
      err_o     <= 1'b0;
      pkt_cnt_o <= 16'd0;
    end else begin
      valid_q <= pop;
      if (pop) data_q <= bus.data_i;
      if (overflow) err_o <= 1'b1;
      // Framing errors are flagged only; the flit is forwarded regardless.
      if (pop) begin
        case (state)
          IDLE: begin
            case (ftype)
              HEAD:    state <= PKT;
              SINGLE:  pkt_cnt_o <= pkt_cnt_o + 16'd1;
              default: err_o <= 1'b1;
            endcase
          end
          PKT: begin
            case (ftype)
              BODY: state <= PKT;
              TAIL: begin
                state     <= IDLE;
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
              end
              HEAD: err_o <= 1'b1;
              SINGLE: begin
                state     <= IDLE;
                err_o     <= 1'b1;
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
              end
            endcase
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nlink_tx.sv
// tb/tb_nlink_tx.sv - scoreboard bench for nlink_tx with a behavioural FIFO/link/credit model
module tb_nlink_tx;
  localparam int W  = 8;
  localparam int CR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  credit_cnt;
  logic        err;
  logic [15:0] pkt;

  always #5 clk = ~clk;

  nlink_tx_if #(.width(W)) bus ();

  nlink_tx #(.width(W), .credits(CR)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .credit_cnt_o (credit_cnt),
    .err_o        (err),
    .pkt_cnt_o    (pkt)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  data;
    logic [15:0] pkt;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fifo[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          armed = 1'b0;
  int          m_cnt = CR;
  logic        m_err = 1'b0;
  logic [15:0] m_pkt = 16'd0;
  bit          m_in = 1'b0;
  int          pushed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    bus.empty_i = (fifo.size() == 0);
    bus.data_i  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fifo.push_back(d);
    refresh();
  endtask

  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = bus.read_o;
    @(posedge clk);
    #1;
    if (rd && fifo.size() != 0) fifo.delete(0);
    refresh();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.credit_i = 1'b0;
    fifo.delete();
    refresh();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Reference model: state as of the last edge; predicts pops, credits, framing.
  always @(negedge clk) begin : model
    logic        exp_rd;
    logic [1:0]  t;
    logic        n_err;
    logic [15:0] n_pkt;
    exp_rd = !rst && fifo.size() != 0 && m_cnt > 0;
    if (armed) begin
      check("credit_cnt_o", 32'(credit_cnt), m_cnt);
      check("err_o", 32'(err), 32'(m_err));
      check("pkt_cnt_o", 32'(pkt), 32'(m_pkt));
      check("read_o", 32'(bus.read_o), 32'(exp_rd));
    end
    if (rst) begin
      m_cnt = CR; m_err = 1'b0; m_pkt = 16'd0; m_in = 1'b0; armed = 1'b1;
    end else if (armed) begin
      n_err = m_err;
      n_pkt = m_pkt;
      if (exp_rd) begin
        t = fifo[0][7:6];
        // t[0] marks a packet start, t[1] a packet end.
        if (t[0] == m_in) n_err = 1'b1;
        if (t[1] && (m_in || t[0])) n_pkt = n_pkt + 16'd1;
        m_in = t[1] ? 1'b0 : (t[0] ? 1'b1 : m_in);
      end
      if (exp_rd && !bus.credit_i) m_cnt--;
      else if (!exp_rd && bus.credit_i) begin
        if (m_cnt == CR) n_err = 1'b1;
        else m_cnt++;
      end
      if (exp_rd) sb.push_back('{cyc, fifo[0], n_pkt, n_err});
      m_err = n_err;
      m_pkt = n_pkt;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (armed) begin
      while (sb.size() != 0 && sb[0].cyc < cyc - 1) begin
        check("stale flit cycle", 32'(sb[0].cyc), 32'(cyc - 1));
        void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].cyc == cyc - 1) begin
        e = sb.pop_front();
        check("valid_o", 32'(bus.valid_o), 32'd1);
        check("data_o", 32'(bus.data_o), 32'(e.data));
        check("flit pkt_cnt_o", 32'(pkt), 32'(e.pkt));
        check("flit err_o", 32'(err), 32'(e.err));
      end else begin
        check("valid_o idle", 32'(bus.valid_o), 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rst = 1'b1;
    bus.credit_i = 1'b0;
    refresh();
    do_reset(2);
    check("reset valid_o", 32'(bus.valid_o), 32'd0);
    check("reset data_o", 32'(bus.data_o), 32'd0);
    check("reset credit_cnt_o", 32'(credit_cnt), 32'd4);
    check("reset err_o", 32'(err), 32'd0);
    check("reset pkt_cnt_o", 32'(pkt), 32'd0);

    // HEAD, BODY, TAIL with no credit return
    push(8'h41); push(8'h02); push(8'h83);
    repeat (5) tick();
    check("hbt credit_cnt_o", 32'(credit_cnt), 32'd1);
    check("hbt pkt_cnt_o", 32'(pkt), 32'd1);
    check("hbt err_o", 32'(err), 32'd0);

    // Six singles, four credits, then a single credit releases one more
    do_reset(2);
    for (int i = 1; i <= 6; i++) push(8'hC0 | 8'(i));
    repeat (8) tick();
    check("stalled read_o", 32'(bus.read_o), 32'd0);
    check("stalled pkt_cnt_o", 32'(pkt), 32'd4);
    bus.credit_i = 1'b1;
    tick();
    bus.credit_i = 1'b0;
    repeat (2) tick();
    check("released credit_cnt_o", 32'(credit_cnt), 32'd0);
    check("released pkt_cnt_o", 32'(pkt), 32'd5);

    // Credit pulsed every cycle from zero: pop+credit holds the count
    for (int i = 0; i < 8; i++) push(8'hC8 | 8'(i));
    repeat (12) begin
      bus.credit_i = 1'b1;
      tick();
    end
    bus.credit_i = 1'b0;
    tick();

    // BODY as first flit after reset
    do_reset(2);
    push(8'h05);
    repeat (3) tick();
    check("orphan body err_o", 32'(err), 32'd1);
    check("orphan body pkt_cnt_o", 32'(pkt), 32'd0);

    // Credit overflow with full count and empty FIFO
    do_reset(2);
    bus.credit_i = 1'b1;
    tick();
    bus.credit_i = 1'b0;
    tick();
    check("overflow err_o", 32'(err), 32'd1);
    check("overflow credit_cnt_o", 32'(credit_cnt), 32'd4);

    // Reset between HEAD and TAIL
    do_reset(2);
    push(8'h41);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midpkt reset valid_o", 32'(bus.valid_o), 32'd0);
    check("midpkt reset data_o", 32'(bus.data_o), 32'd0);
    check("midpkt reset credit_cnt_o", 32'(credit_cnt), 32'd4);
    check("midpkt reset err_o", 32'(err), 32'd0);
    check("midpkt reset pkt_cnt_o", 32'(pkt), 32'd0);
    push(8'h83);
    repeat (3) tick();
    check("lone tail err_o", 32'(err), 32'd1);
    check("lone tail pkt_cnt_o", 32'(pkt), 32'd0);

    // Randomised flits, credits and occasional resets
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      if (fifo.size() < 6 && ($urandom % 2) == 0) push(8'($urandom));
      bus.credit_i = (($urandom % 3) == 0) && (m_cnt < CR);
      rst = (($urandom % 100) == 0);
      tick();
    end
    rst = 1'b0;
    bus.credit_i = 1'b0;
    repeat (3) tick();

    // 65536 singles at full rate wrap the packet counter
    do_reset(2);
    pushed = 0;
    for (int i = 0; i < 70000 && (pushed < 65536 || fifo.size() != 0); i++) begin
      while (pushed < 65536 && fifo.size() < 4) begin
        push(8'hC0 | 8'(pushed % 64));
        pushed++;
      end
      bus.credit_i = 1'b1;
      tick();
    end
    bus.credit_i = 1'b0;
    repeat (2) tick();
    check("wrap pushed", 32'(pushed), 32'd65536);
    check("wrap pkt_cnt_o", 32'(pkt), 32'd0);
    check("wrap err_o", 32'(err), 32'd0);

    repeat (3) tick();
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
